// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source; define VGA_TIMING_TEST_PATTERN_EN for colour bars on rgb_out
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        frame_start
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic POL = 1'(SYNC_POL);
  logic [10:0] h_nxt, v_nxt;
  logic        h_wrap;
  logic [11:0] rgb_nxt;
  // Flags are derived from the next counter values so they land on the same cycle as the counts.
  always_comb begin
    h_wrap = hcount_out == H_LAST;
    h_nxt  = h_wrap ? '0 : hcount_out + 11'd1;
    v_nxt  = h_wrap ? (vcount_out == V_LAST ? '0 : vcount_out + 11'd1) : vcount_out;
  end
`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
  localparam logic [95:0] BARS = {12'h000, 12'h00f, 12'hf00, 12'hf0f,
                                  12'h0f0, 12'h0ff, 12'hff0, 12'hfff};
  logic [2:0] bar;
  always_comb begin
    bar     = 3'(h_nxt / BAR_W);
    rgb_nxt = (h_nxt >= HA || v_nxt >= VA) ? '0 : BARS[12*bar +: 12];
  end
`else
  assign rgb_nxt = '0;
`endif
  always_ff @(posedge pclk) begin
    if (!rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      hsync_out   <= ~POL;
      vsync_out   <= ~POL;
      rgb_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount_out  <= h_nxt;
      vcount_out  <= v_nxt;
      hblnk_out   <= h_nxt >= HA;
      vblnk_out   <= v_nxt >= VA;
      hsync_out   <= (h_nxt >= HS0 && h_nxt < HS1) ? POL : ~POL;
      vsync_out   <= (v_nxt >= VS0 && v_nxt < VS1) ? POL : ~POL;
      rgb_out     <= rgb_nxt;
      frame_start <= h_nxt == '0 && v_nxt == '0;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: reduced-geometry raster checked against a pixel-index model under random resets
module tb_vga_timing_gen;
  localparam int HA = 80, HFP = 4, HSY = 12, HBP = 8;
  localparam int VA = 20, VFP = 1, VSY = 2, VBP = 3;
  localparam int POL = 0;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out, frame_start;
  logic [11:0] rgb_out;
  int compared = 0, mismatched = 0;
  logic [11:0] bars [8] = '{12'hfff, 12'hff0, 12'h0ff, 12'h0f0, 12'hf0f, 12'hf00, 12'h00f, 12'h000};
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(POL)
  ) dut (
    .pclk(pclk), .rst(rst), .hcount_out(hcount_out), .hsync_out(hsync_out),
    .hblnk_out(hblnk_out), .vcount_out(vcount_out), .vsync_out(vsync_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out), .frame_start(frame_start)
  );
  always #5 pclk = ~pclk;
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // n = number of running edges since the last reset; the raster is just pixel index n mod frame size
  task automatic check(input int n);
    int p, h, v;
    logic [11:0] rgb;
    p = n % FT;
    h = p % HT;
    v = p / HT;
    rgb = 12'h000;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (h < HA && v < VA) rgb = bars[h / (HA / 8)];
`endif
    cmp("hcount", 32'(hcount_out), 32'(h));
    cmp("vcount", 32'(vcount_out), 32'(v));
    cmp("hblnk", 32'(hblnk_out), 32'(n > 0 && h >= HA));
    cmp("vblnk", 32'(vblnk_out), 32'(n > 0 && v >= VA));
    cmp("hsync", 32'(hsync_out), 32'((n > 0 && h >= HA + HFP && h < HA + HFP + HSY) ? POL : 1 - POL));
    cmp("vsync", 32'(vsync_out), 32'((n > 0 && v >= VA + VFP && v < VA + VFP + VSY) ? POL : 1 - POL));
    cmp("rgb", 32'(rgb_out), 32'(rgb));
    cmp("frame_start", 32'(frame_start), 32'(n > 0 && p == 0));
  endtask
  initial begin
    int n, len, fs_seen;
    rst = 1'b0;
    repeat (5) begin
      @(posedge pclk); #1 check(0);
    end
    rst = 1'b1;
    n = 0;
    fs_seen = 0;
    repeat (2 * FT + 50) begin
      @(posedge pclk); #1 n++;
      check(n);
      fs_seen += int'(frame_start);
    end
    cmp("frame_start_count", 32'(fs_seen), 32'd2);
    repeat (6) begin
      len = $urandom_range(1, 3);
      rst = 1'b0;
      repeat (len) begin
        @(posedge pclk); #1 check(0);
      end
      rst = 1'b1;
      n = 0;
      len = $urandom_range(1, FT + HT);
      repeat (len) begin
        @(posedge pclk); #1 n++;
        check(n);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
